// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle control unit: state codes, opcodes,
// datapath mux/ALU encodings, fault codes and the opcode decoder.
package mc_ctrl_pkg;

    typedef enum logic [4:0] {
        S_RESET  = 5'd0,
        S_FETCH  = 5'd1,
        S_DECODE = 5'd2,
        S_ALU    = 5'd3,
        S_SHIFT  = 5'd4,
        S_WB     = 5'd5,
        S_ORI1   = 5'd6,
        S_ORI2   = 5'd7,
        S_ORI3   = 5'd8,
        S_LOAD   = 5'd9,
        S_LOADWB = 5'd10,
        S_STORE  = 5'd11,
        S_BR     = 5'd12,
        S_JR     = 5'd13,
        S_JAL1   = 5'd14,
        S_JAL2   = 5'd15,
        S_JAL3   = 5'd16,
        S_JAL4   = 5'd17,
        S_LDI1   = 5'd18,
        S_LDI2   = 5'd19,
        S_LDI3   = 5'd20,
        S_TRAP   = 5'd21
    } state_t;

    typedef enum logic [1:0] {
        FAULT_NONE    = 2'b00,
        FAULT_ILLEGAL = 2'b01,
        FAULT_TIMEOUT = 2'b10
    } fault_t;

    // Full 4-bit opcodes
    localparam logic [3:0] OP_LOAD  = 4'b0000;
    localparam logic [3:0] OP_LDI   = 4'b0001;
    localparam logic [3:0] OP_STORE = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0100;
    localparam logic [3:0] OP_BZ    = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_NAND  = 4'b1000;
    localparam logic [3:0] OP_BNZ   = 4'b1001;
    localparam logic [3:0] OP_JAL   = 4'b1100;
    localparam logic [3:0] OP_BPZ   = 4'b1101;
    localparam logic [3:0] OP_JR    = 4'b1110;

    // Opcode families identified by the low three bits only
    localparam logic [2:0] OPL_SHIFT = 3'b011;
    localparam logic [2:0] OPL_ORI   = 3'b111;

    // ALU operand-B select
    localparam logic [2:0] ALU2_REG  = 3'b000;
    localparam logic [2:0] ALU2_ONE  = 3'b001;
    localparam logic [2:0] ALU2_IMM4 = 3'b010;
    localparam logic [2:0] ALU2_IMM5 = 3'b011;
    localparam logic [2:0] ALU2_IMM3 = 3'b100;
    localparam logic [2:0] ALU2_IMM8 = 3'b101;

    // ALU operation
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_OR    = 3'b010;
    localparam logic [2:0] ALU_NAND  = 3'b011;
    localparam logic [2:0] ALU_SHIFT = 3'b100;

    // Memory address source
    localparam logic [1:0] ADDR_ALU = 2'b00;
    localparam logic [1:0] ADDR_PC  = 2'b01;
    localparam logic [1:0] ADDR_MDR = 2'b10;

    // States that wait on mem_ready and are guarded by the watchdog
    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_LOAD) || (s == S_STORE) ||
               (s == S_LDI1)  || (s == S_LDI2);
    endfunction

    // First execute state for an opcode; S_TRAP marks an illegal opcode
    function automatic state_t decode_op(input logic [3:0] op);
        state_t nxt;
        case (op)
            OP_ADD, OP_SUB, OP_NAND: nxt = S_ALU;
            OP_LOAD:                 nxt = S_LOAD;
            OP_STORE:                nxt = S_STORE;
            OP_BPZ, OP_BZ, OP_BNZ:   nxt = S_BR;
            OP_JR:                   nxt = S_JR;
            OP_JAL:                  nxt = S_JAL1;
            OP_LDI:                  nxt = S_LDI1;
            default: begin
                if (op[2:0] == OPL_SHIFT)    nxt = S_SHIFT;
                else if (op[2:0] == OPL_ORI) nxt = S_ORI1;
                else                         nxt = S_TRAP;
            end
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory watchdog: counts stalled cycles and flags the one that would reach
// the TIMEOUT limit. A TIMEOUT of 0 disables it.
module mc_wait_timer #(
    parameter int TIMEOUT = 15,
    parameter int TMR_W   = 4
) (
    input  logic clock,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TMR_W-1:0] LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [TMR_W-1:0] count;

    // Stall counter; saturates so a disabled watchdog never wraps into a false hit
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    // The stalled cycle that completes TIMEOUT waits is the expiry cycle
    assign expired = (TIMEOUT != 0) && enable && (count == LAST);

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle processor control unit: state machine, combinational datapath
// controls, sticky fault code and retired-instruction counter.
module mc_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int TMR_W   = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [3:0]       instr,
    input  logic             N,
    input  logic             Z,
    input  logic             mem_ready,
    output logic             PCwrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRload,
    output logic             OpASel,
    output logic             MDRload,
    output logic             OpABLoad,
    output logic             ALU1,
    output logic             ALUOutWrite,
    output logic             RFWrite,
    output logic             RegIn,
    output logic             FlagWrite,
    output logic             MDRsel,
    output logic [1:0]       AddrSel,
    output logic [2:0]       ALU2,
    output logic [2:0]       ALUop,
    output logic [4:0]       state_o,
    output logic             retire,
    output logic [CNT_W-1:0] instr_count,
    output logic [1:0]       fault
);

    state_t state, state_next;
    fault_t fault_q, fault_next;
    logic   wd_clear, wd_enable, wd_expired;

    // Watchdog restarts on every state change and counts only stalled memory cycles
    assign wd_enable = is_mem_state(state) && !mem_ready;
    assign wd_clear  = (state_next != state);

    mc_wait_timer #(
        .TIMEOUT(TIMEOUT),
        .TMR_W  (TMR_W)
    ) u_wait_timer (
        .clock  (clock),
        .resetn (resetn),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expired(wd_expired)
    );

    // Next-state and fault selection
    always_comb begin
        state_next = state;
        fault_next = fault_q;
        case (state)
            S_RESET:  state_next = S_FETCH;
            S_FETCH:  if (mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                state_next = decode_op(instr);
                if (state_next == S_TRAP) fault_next = FAULT_ILLEGAL;
            end
            S_ALU, S_SHIFT: state_next = S_WB;
            S_ORI1:   state_next = S_ORI2;
            S_ORI2:   state_next = S_ORI3;
            S_LOAD:   if (mem_ready) state_next = S_LOADWB;
            S_STORE:  if (mem_ready) state_next = S_FETCH;
            S_JAL1:   state_next = S_JAL2;
            S_JAL2:   state_next = S_JAL3;
            S_JAL3:   state_next = S_JAL4;
            S_LDI1:   if (mem_ready) state_next = S_LDI2;
            S_LDI2:   if (mem_ready) state_next = S_LDI3;
            S_WB, S_ORI3, S_LOADWB, S_BR, S_JR, S_JAL4, S_LDI3:
                      state_next = S_FETCH;
            S_TRAP:   state_next = S_TRAP;
            default:  state_next = S_TRAP;
        endcase
        // wd_expired already implies a stalled memory state
        if (wd_expired) begin
            state_next = S_TRAP;
            fault_next = FAULT_TIMEOUT;
        end
    end

    // Datapath controls decoded from the current state and live inputs
    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        PCwrite     = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRload      = 1'b0;
        OpASel      = 1'b0;
        MDRload     = 1'b0;
        OpABLoad    = 1'b0;
        ALU1        = 1'b0;
        ALUOutWrite = 1'b0;
        RFWrite     = 1'b0;
        RegIn       = 1'b0;
        FlagWrite   = 1'b0;
        MDRsel      = 1'b0;
        AddrSel     = ADDR_ALU;
        ALU2        = ALU2_REG;
        ALUop       = ALU_ADD;
        retire      = 1'b0;
        case (state)
            S_FETCH: begin
                AddrSel = ADDR_PC;
                MemRead = 1'b1;
                ALU2    = ALU2_ONE;
                PCwrite = mem_ready;
                IRload  = mem_ready;
            end
            S_DECODE: OpABLoad = 1'b1;
            S_ALU: begin
                ALU1        = 1'b1;
                ALUOutWrite = 1'b1;
                FlagWrite   = 1'b1;
                case (instr)
                    OP_SUB:  ALUop = ALU_SUB;
                    OP_NAND: ALUop = ALU_NAND;
                    default: ALUop = ALU_ADD;
                endcase
            end
            S_SHIFT: begin
                ALU1        = 1'b1;
                ALU2        = ALU2_IMM3;
                ALUop       = ALU_SHIFT;
                ALUOutWrite = 1'b1;
                FlagWrite   = 1'b1;
            end
            S_WB: begin
                RFWrite = 1'b1;
                retire  = 1'b1;
            end
            S_ORI1: begin
                OpASel   = 1'b1;
                OpABLoad = 1'b1;
            end
            S_ORI2: begin
                ALU1        = 1'b1;
                ALU2        = ALU2_IMM5;
                ALUop       = ALU_OR;
                ALUOutWrite = 1'b1;
                FlagWrite   = 1'b1;
            end
            S_ORI3: begin
                OpASel  = 1'b1;
                RFWrite = 1'b1;
                retire  = 1'b1;
            end
            S_LOAD: begin
                MemRead = 1'b1;
                MDRload = mem_ready;
            end
            S_LOADWB: begin
                ALUOutWrite = 1'b1;
                RFWrite     = 1'b1;
                RegIn       = 1'b1;
                retire      = 1'b1;
            end
            S_STORE: begin
                MemWrite = 1'b1;
                retire   = mem_ready;
            end
            S_BR: begin
                ALU2   = ALU2_IMM4;
                retire = 1'b1;
                case (instr)
                    OP_BPZ:  PCwrite = ~N;
                    OP_BZ:   PCwrite = Z;
                    OP_BNZ:  PCwrite = ~Z;
                    default: PCwrite = 1'b0;
                endcase
            end
            S_JR: begin
                ALU1    = 1'b1;
                ALU2    = ALU2_IMM8;
                PCwrite = 1'b1;
                retire  = 1'b1;
            end
            S_JAL1: begin
                ALU2        = ALU2_IMM8;
                ALUOutWrite = 1'b1;
            end
            S_JAL2: begin
                OpASel  = 1'b1;
                RFWrite = 1'b1;
            end
            S_JAL3: begin
                OpASel   = 1'b1;
                OpABLoad = 1'b1;
            end
            S_JAL4: begin
                ALU1    = 1'b1;
                ALU2    = ALU2_IMM4;
                PCwrite = 1'b1;
                retire  = 1'b1;
            end
            S_LDI1: begin
                MemRead = 1'b1;
                MDRload = mem_ready;
            end
            S_LDI2: begin
                AddrSel = ADDR_MDR;
                MDRsel  = 1'b1;
                MemRead = 1'b1;
                MDRload = mem_ready;
            end
            S_LDI3: begin
                OpASel  = 1'b1;
                RFWrite = 1'b1;
                RegIn   = 1'b1;
                retire  = 1'b1;
            end
            default: ;
        endcase
    end

    // State, sticky fault and retired-instruction count
    always_ff @(posedge clock or negedge resetn) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!resetn) begin
            state       <= S_RESET;
            fault_q     <= FAULT_NONE;
            instr_count <= '0;
        end else begin
            state   <= state_next;
            fault_q <= fault_next;
            if (retire) instr_count <= instr_count + 1'b1;
        end
    end

    assign state_o = state;
    assign fault   = fault_q;

endmodule
